secded_stream_decoder: RTL
==========================

Name: secded_stream_decoder

Overview:
- Parametrised, pipelined SECDED (extended Hamming) decoder; next generation of the team's fixed Hamming(7,4) decoder.
- Generalised data width; adds an overall-parity bit for double-error detection.
- Adds a valid/ready streaming interface with backpressure and registered outputs.
- Sits between a memory or link read port and the consumer; pairs with the matching SECDED encoder.

Parameters:
- DATA_W, 4, data bits per word; legal range 4..57.
- P_W, derived (localparam), smallest p with 2^p >= DATA_W+p+1; DATA_W=4 gives 3.
- N, derived (localparam), DATA_W+P_W; number of Hamming positions 1..N.
- CNT_W, 16, width of the error counters (optional feature only).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input codeword valid.
- in_ready  out  1  decoder can accept a codeword this cycle.
- in_code  in  N+1  received codeword; bit 0 = overall parity; bits 1..N = Hamming positions.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_W  corrected data; LSB = lowest data position.
- out_syndrome  out  P_W  raw syndrome of the word.
- out_sec  out  1  single error detected and corrected.
- out_ded  out  1  uncorrectable error detected.
- cnt_clr  in  1  synchronous clear of the counters (optional feature).
- sec_cnt  out  CNT_W  corrected-error count (optional feature).
- ded_cnt  out  CNT_W  uncorrectable-error count (optional feature).

Behaviour:
- Codeword layout: power-of-two positions (1,2,4,...) are parity; the remaining positions hold data bits in ascending order, d0 at position 3.
- Syndrome bit k = XOR of all positions whose index has bit k set. par = XOR of in_code[N:0].
- Stage 1 registers the codeword, syndrome and par. Stage 2 registers the corrected data and flags.
- Latency: exactly 2 cycles from input handshake to out_valid when out_ready is held high. Throughput: 1 word per cycle.
- Stage-2 load: s2_load = s1_valid && (!s2_valid || out_ready).
- in_ready = !s1_valid || s2_load (combinational from out_ready; no combinational path from in_valid).
- out_valid/data/flags stay stable while out_valid && !out_ready.
- Classification:
  - syn=0, par=0: clean; sec=0, ded=0.
  - par=1, syn=0: overall-parity bit error; data untouched; sec=1.
  - par=1, 1<=syn<=N: flip position syn, then extract data; sec=1.
  - par=1, syn>N: ded=1; data passed raw.
  - par=0, syn!=0: ded=1; data passed raw.
- sec and ded are never both 1.
- Reset: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_syndrome=0, out_sec=0, out_ded=0, counters=0.
- Reset asserted mid-stream discards all in-flight words; in_ready=1 on the first cycle after release.

Optional Feature:
- Macro SECDED_ERR_CNT_EN.
- Defined:
  - sec_cnt/ded_cnt increment by 1 when an output handshake (out_valid && out_ready) carries sec/ded.
  - Both counters saturate at 2^CNT_W-1.
  - cnt_clr zeroes both counters next cycle and takes priority over a simultaneous increment.
- Undefined: counter registers are absent; sec_cnt and ded_cnt are tied to 0; cnt_clr is ignored.

Test Plan (DATA_W=4, N=7, in_code 8 bits):
- in_code=8'hAA, out_ready=1 -> 2 cycles later out_data=4'hB, syndrome=0, sec=0, ded=0.
- in_code=8'h8A (position 5 flipped) -> out_data=4'hB, syndrome=3'd5, sec=1, ded=0.
- in_code=8'hAB (overall parity flipped) -> out_data=4'hB, syndrome=0, sec=1.
- in_code=8'hCA (positions 5,6 flipped) -> out_data=4'hD (raw), syndrome=3'd3, ded=1, sec=0.
- Back-to-back valid words with out_ready=0 for 3 cycles -> in_ready falls after 2 accepted; outputs held stable; no loss or duplication after out_ready=1.
- SECDED_ERR_CNT_EN, CNT_W=2: 4 single-error words -> sec_cnt=3 (saturated); then cnt_clr=1 together with a 5th single-error handshake -> sec_cnt=0. Also pulse rst_n low mid-stream -> all outputs return to 0.

Source files
------------

// File: rtl/secded_stream_decoder_if.sv
// secded_stream_decoder_if: valid/ready stream bundle for the SECDED decoder.
//   in_valid/in_ready/in_code          : received codeword stream (bit 0 = overall parity,
//                                        bits 1..N = Hamming positions)
//   out_valid/out_ready                : decoded result stream
//   out_data/out_syndrome/out_sec/ded  : corrected data, raw syndrome, error flags
// Modports: master = producer of codewords / consumer of results, slave = decoder.
interface secded_stream_decoder_if #(
    parameter int unsigned DATA_W = 4
);
    // Smallest p with 2^p >= DATA_W + p + 1.
    function automatic int unsigned calc_p_w(input int unsigned dw);
        int unsigned p;
        p = 0;
        for (int unsigned q = 1; q <= 7; q++) begin
            if (p == 0 && (32'd1 << q) >= dw + q + 1) p = q;
        end
        return p;
    endfunction

    localparam int unsigned P_W = calc_p_w(DATA_W);
    localparam int unsigned N   = DATA_W + P_W;

    logic              in_valid;
    logic              in_ready;
    logic [N:0]        in_code;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [P_W-1:0]    out_syndrome;
    logic              out_sec;
    logic              out_ded;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data, out_syndrome, out_sec, out_ded
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data, out_syndrome, out_sec, out_ded
    );
endinterface

// File: rtl/secded_stream_decoder.sv
// secded_stream_decoder: two-stage pipelined SECDED (extended Hamming) decoder with
// valid/ready backpressure.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : codeword input stream and decoded output stream
//   cnt_clr     : synchronous clear of the error counters
//   sec_cnt     : corrected-error count (saturating)
//   ded_cnt     : uncorrectable-error count (saturating)
// Optional feature macro SECDED_ERR_CNT_EN: when undefined the counters are absent,
// sec_cnt/ded_cnt read 0 and cnt_clr is ignored.
module secded_stream_decoder #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    secded_stream_decoder_if.slave bus,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       sec_cnt,
    output logic [CNT_W-1:0]       ded_cnt
);
    // Smallest p with 2^p >= DATA_W + p + 1.
    function automatic int unsigned calc_p_w(input int unsigned dw);
        int unsigned p;
        p = 0;
        for (int unsigned q = 1; q <= 7; q++) begin
            if (p == 0 && (32'd1 << q) >= dw + q + 1) p = q;
        end
        return p;
    endfunction

    localparam int unsigned P_W = calc_p_w(DATA_W);
    localparam int unsigned N   = DATA_W + P_W;
    localparam int unsigned CW  = N + 1;

    // Positions (bit 0 = overall parity) that contribute to syndrome bit k.
    function automatic logic [CW-1:0] syn_mask(input int unsigned k);
        logic [CW-1:0] m;
        m = '0;
        for (int unsigned p = 1; p <= N; p++) begin
            if (((p >> k) & 32'd1) != 0) m = m | (CW'(1) << p);
        end
        return m;
    endfunction

    // Hamming position holding data bit idx (non-power-of-two positions, ascending).
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned cnt;
        int unsigned pos;
        cnt = 0;
        pos = 0;
        for (int unsigned p = 3; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    // Stage 1: registered codeword (positions 1..N at bits 0..N-1), syndrome, parity
    logic              s1_valid_q, s1_valid_d;
    logic [N-1:0]      s1_code_q,  s1_code_d;
    logic [P_W-1:0]    s1_syn_q,   s1_syn_d;
    logic              s1_par_q,   s1_par_d;

    // Stage 2: registered outputs
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [P_W-1:0]    out_syn_q,   out_syn_d;
    logic              out_sec_q,   out_sec_d;
    logic              out_ded_q,   out_ded_d;

    logic              s2_load_c;
    logic              in_ready_c;
    logic              in_fire_c;
    logic [P_W-1:0]    syn_c;
    logic              in_range_c;
    logic              sec_c;
    logic              ded_c;
    logic [N-1:0]      flip_c;
    logic [N-1:0]      corr_c;
    logic [DATA_W-1:0] data_c;

    // Handshake: stage 2 loads when empty or draining; stage 1 accepts when it can move on.
    assign s2_load_c  = s1_valid_q && (!out_valid_q || bus.out_ready);
    assign in_ready_c = !s1_valid_q || s2_load_c;
    assign in_fire_c  = bus.in_valid && in_ready_c;

    // Syndrome of the incoming word, one XOR tree per bit.
    for (genvar k = 0; k < P_W; k++) begin : g_syn
        localparam logic [CW-1:0] MASK = syn_mask(k);
        assign syn_c[k] = ^(bus.in_code & MASK);
    end

    // Classification: odd parity with an in-range syndrome is a single error
    // (syndrome 0 means the overall-parity bit itself flipped).
    assign in_range_c = (32'(s1_syn_q) <= N);
    assign sec_c      = s1_par_q && in_range_c;
    assign ded_c      = (s1_syn_q != '0) && (!s1_par_q || !in_range_c);
    assign flip_c     = (sec_c && s1_syn_q != '0) ? (N'(1) << (s1_syn_q - P_W'(1))) : '0;
    assign corr_c     = s1_code_q ^ flip_c;

    // Data extraction from the non-parity positions.
    for (genvar i = 0; i < DATA_W; i++) begin : g_data
        localparam int unsigned POS = data_pos(i);
        assign data_c[i] = corr_c[POS-1];
    end

    // Next-state for both pipeline stages.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_code_d   = s1_code_q;
        s1_syn_d    = s1_syn_q;
        s1_par_d    = s1_par_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_syn_d   = out_syn_q;
        out_sec_d   = out_sec_q;
        out_ded_d   = out_ded_q;

        if (s2_load_c) begin
            out_valid_d = 1'b1;
            out_data_d  = data_c;
            out_syn_d   = s1_syn_q;
            out_sec_d   = sec_c;
            out_ded_d   = ded_c;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (in_fire_c) begin
            s1_valid_d = 1'b1;
            s1_code_d  = bus.in_code[N:1];
            s1_syn_d   = syn_c;
            s1_par_d   = ^bus.in_code;
        end else if (s2_load_c) begin
            s1_valid_d = 1'b0;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_code_q   <= '0;
            s1_syn_q    <= '0;
            s1_par_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_syn_q   <= '0;
            out_sec_q   <= 1'b0;
            out_ded_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_code_q   <= s1_code_d;
            s1_syn_q    <= s1_syn_d;
            s1_par_q    <= s1_par_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_syn_q   <= out_syn_d;
            out_sec_q   <= out_sec_d;
            out_ded_q   <= out_ded_d;
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_syndrome = out_syn_q;
    assign bus.out_sec      = out_sec_q;
    assign bus.out_ded      = out_ded_q;

`ifdef SECDED_ERR_CNT_EN
    logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [CNT_W-1:0] ded_cnt_q, ded_cnt_d;
    logic             out_hs_c;

    assign out_hs_c = out_valid_q && bus.out_ready;

    // Saturating counters of delivered errors; clear wins over increment.
    always_comb begin
        sec_cnt_d = sec_cnt_q;
        ded_cnt_d = ded_cnt_q;
        if (cnt_clr) begin
            sec_cnt_d = '0;
            ded_cnt_d = '0;
        end else if (out_hs_c) begin
            if (out_sec_q && sec_cnt_q != '1) sec_cnt_d = sec_cnt_q + CNT_W'(1);
            if (out_ded_q && ded_cnt_q != '1) ded_cnt_d = ded_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else begin
            sec_cnt_q <= sec_cnt_d;
            ded_cnt_q <= ded_cnt_d;
        end
    end

    assign sec_cnt = sec_cnt_q;
    assign ded_cnt = ded_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign sec_cnt        = '0;
    assign ded_cnt        = '0;
`endif

endmodule
